// File: rtl/esn_ctrl_pkg.sv
// rtl/esn_ctrl_pkg.sv - shared state and operand-source encodings for the ESN step sequencer
package esn_ctrl_pkg;

    localparam logic [6:0] IDLE    = 7'b0000001;
    localparam logic [6:0] RES_IN  = 7'b0000010;
    localparam logic [6:0] RES_REC = 7'b0000100;
    localparam logic [6:0] RES_WB  = 7'b0001000;
    localparam logic [6:0] RO_MAC  = 7'b0010000;
    localparam logic [6:0] RO_WB   = 7'b0100000;
    localparam logic [6:0] DONE    = 7'b1000000;

    localparam logic [1:0] SRC_IN    = 2'd0;
    localparam logic [1:0] SRC_STATE = 2'd1;
    localparam logic [1:0] SRC_NONE  = 2'd2;

endpackage

// File: rtl/idx_counter.sv
// rtl/idx_counter.sv - wrapping index counter with a per-cycle selectable limit
module idx_counter #(
    parameter int IW    = 8,
    parameter int LIMIT = 1
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          en,
    input  logic          clr,
    input  logic [IW:0]   limit,
    output logic [IW-1:0] count,
    output logic          last
);

    localparam logic [IW:0] DEF_LIMIT = (IW+1)'(LIMIT);

    // A zero limit input falls back to the static LIMIT.
    logic [IW:0] effLimit;
    assign effLimit = (limit == '0) ? DEF_LIMIT : limit;
    assign last     = ({1'b0, count} == (effLimit - (IW+1)'(1)));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + IW'(1);
        end
    end

endmodule

// File: rtl/esn_step_sequencer.sv
// rtl/esn_step_sequencer.sv - sequences one ESN timestep (reservoir then readout) over a shared MAC
module esn_step_sequencer
    import esn_ctrl_pkg::*;
#(
    parameter int N_NEUR = 16,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 2,
    parameter int IW     = 8
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iStart,
    input  logic          iHold,
    output logic          oBusy,
    output logic          oDone,
    output logic          oMacEn,
    output logic          oMacClr,
    output logic [1:0]    oSrcSel,
    output logic [IW-1:0] oRowIdx,
    output logic [IW-1:0] oColIdx,
    output logic          oRdBank,
    output logic          oStateWrEn,
    output logic          oOutWrEn,
    output logic          oReadSel
);

    localparam logic [IW:0] LIM_IN   = (IW+1)'(N_IN);
    localparam logic [IW:0] LIM_NEUR = (IW+1)'(N_NEUR);
    localparam logic [IW:0] LIM_OUT  = (IW+1)'(N_OUT);

    logic [6:0]  state;
    logic [6:0]  stateNext;
    logic        rdBank;
    logic        colLast;
    logic        rowLast;
    logic        colEn;
    logic        rowEn;
    logic [IW:0] colLimit;
    logic [IW:0] rowLimit;

    assign colEn    = ((state == RES_IN) || (state == RES_REC) || (state == RO_MAC)) && !iHold;
    assign rowEn    = ((state == RES_WB) || (state == RO_WB)) && !iHold;
    assign colLimit = (state == RES_IN) ? LIM_IN : LIM_NEUR;
    assign rowLimit = (state == RES_WB) ? LIM_NEUR : LIM_OUT;

    idx_counter #(.IW(IW), .LIMIT(N_NEUR)) uColCnt (
        .iClk  (iClk),
        .iRst  (iRst),
        .en    (colEn),
        .clr   (state == IDLE),
        .limit (colLimit),
        .count (oColIdx),
        .last  (colLast)
    );

    idx_counter #(.IW(IW), .LIMIT(N_NEUR)) uRowCnt (
        .iClk  (iClk),
        .iRst  (iRst),
        .en    (rowEn),
        .clr   (state == IDLE),
        .limit (rowLimit),
        .count (oRowIdx),
        .last  (rowLast)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iStart) stateNext = RES_IN;
            RES_IN:  if (!iHold && colLast) stateNext = RES_REC;
            RES_REC: if (!iHold && colLast) stateNext = RES_WB;
            RES_WB:  if (!iHold) stateNext = rowLast ? RO_MAC : RES_IN;
            RO_MAC:  if (!iHold && colLast) stateNext = RO_WB;
            RO_WB:   if (!iHold) stateNext = rowLast ? DONE : RO_MAC;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Bank swap happens in DONE so the next timestep reads what this one wrote.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state  <= IDLE;
            rdBank <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == DONE) rdBank <= ~rdBank;
        end
    end

    always_comb begin
        oSrcSel    = SRC_NONE;
        oReadSel   = 1'b0;
        oMacEn     = 1'b0;
        oMacClr    = 1'b0;
        oStateWrEn = 1'b0;
        oOutWrEn   = 1'b0;
        case (state)
            RES_IN: begin
                oSrcSel = SRC_IN;
                oMacEn  = !iHold;
                oMacClr = !iHold && (oColIdx == '0);
            end
            RES_REC: begin
                oSrcSel = SRC_STATE;
                oMacEn  = !iHold;
            end
            RES_WB: oStateWrEn = !iHold;
            RO_MAC: begin
                oSrcSel  = SRC_STATE;
                oReadSel = 1'b1;
                oMacEn   = !iHold;
                oMacClr  = !iHold && (oColIdx == '0);
            end
            RO_WB: begin
                oReadSel = 1'b1;
                oOutWrEn = !iHold;
            end
            default: ;
        endcase
    end

    assign oBusy   = (state != IDLE);
    assign oDone   = (state == DONE);
    assign oRdBank = rdBank;

endmodule

// File: tb/tb_esn_step_sequencer.sv
// tb/tb_esn_step_sequencer.sv - scoreboard bench for the ESN step sequencer (default and degenerate sizes)
module tb_esn_step_sequencer;

    logic iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic       rst, start, hold;
    logic       busy, done, macEn, macClr, rdBank, stWr, outWr, readSel;
    logic [1:0] srcSel;
    logic [7:0] row, col;

    logic       dRst, dStart, dHold;
    logic       dBusy, dDone, dMacEn, dMacClr, dRdBank, dStWr, dOutWr, dReadSel;
    logic [1:0] dSrcSel;
    logic [7:0] dRow, dCol;

    esn_step_sequencer #(.N_NEUR(16), .N_IN(4), .N_OUT(2), .IW(8)) uDut (
        .iClk(iClk), .iRst(rst), .iStart(start), .iHold(hold),
        .oBusy(busy), .oDone(done), .oMacEn(macEn), .oMacClr(macClr),
        .oSrcSel(srcSel), .oRowIdx(row), .oColIdx(col), .oRdBank(rdBank),
        .oStateWrEn(stWr), .oOutWrEn(outWr), .oReadSel(readSel)
    );

    esn_step_sequencer #(.N_NEUR(1), .N_IN(1), .N_OUT(1), .IW(8)) uDeg (
        .iClk(iClk), .iRst(dRst), .iStart(dStart), .iHold(dHold),
        .oBusy(dBusy), .oDone(dDone), .oMacEn(dMacEn), .oMacClr(dMacClr),
        .oSrcSel(dSrcSel), .oRowIdx(dRow), .oColIdx(dCol), .oRdBank(dRdBank),
        .oStateWrEn(dStWr), .oOutWrEn(dOutWr), .oReadSel(dReadSel)
    );

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int nChecks = 0;
    int nFails  = 0;
    int wbQ[$];
    int outQ[$];
    int doneQ[$];
    int macEnCnt = 0;
    int macClrCnt = 0;
    int busyErr = 0;
    int dDoneCnt = 0;
    bit monEn = 1'b1;
    bit holdActive = 1'b0;
    logic [8:0] degExp [1:7];

    task automatic checkEq(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pushStep(input int bank, input int doneCyc);
        for (int r = 0; r < 16; r++) wbQ.push_back(r);
        for (int r = 0; r < 2; r++) outQ.push_back(bank * 256 + r);
        doneQ.push_back(doneCyc);
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (doneQ.size() != 0 && n < budget) begin
            @(negedge iClk);
            n++;
        end
        @(negedge iClk);
        checkEq("done within budget", doneQ.size(), 0);
    endtask

    always @(negedge iClk) begin
        #1;
        if (monEn) begin
            if (macEn) macEnCnt++;
            if (macClr) macClrCnt++;
            if (stWr) begin
                if (wbQ.size() == 0) checkEq("stateWr expected", wbQ.size(), 1);
                else checkEq("stateWr row", int'(row), wbQ.pop_front());
            end
            if (outWr) begin
                if (outQ.size() == 0) checkEq("outWr expected", outQ.size(), 1);
                else checkEq("outWr bank*256+row", int'(rdBank) * 256 + int'(row), outQ.pop_front());
            end
            if (done) begin
                if (doneQ.size() == 0) checkEq("done expected", doneQ.size(), 1);
                else checkEq("done cycle", cyc, doneQ.pop_front());
            end
            if (holdActive) begin
                checkEq("hold enables", int'({macEn, macClr, stWr, outWr}), 0);
                checkEq("hold row", int'(row), 3);
                checkEq("hold col", int'(col), 7);
            end
        end
        if (dDone) dDoneCnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        degExp[1] = 9'b1_0_1_1_0_0_0_00;
        degExp[2] = 9'b1_0_1_0_0_0_0_01;
        degExp[3] = 9'b1_0_0_0_1_0_0_10;
        degExp[4] = 9'b1_0_1_1_0_0_1_01;
        degExp[5] = 9'b1_0_0_0_0_1_1_10;
        degExp[6] = 9'b1_1_0_0_0_0_0_10;
        degExp[7] = 9'b0_0_0_0_0_0_0_10;

        rst = 1'b1; start = 1'b0; hold = 1'b0;
        dRst = 1'b1; dStart = 1'b0; dHold = 1'b0;
        repeat (2) @(negedge iClk);
        #1;
        checkEq("reset busy", int'(busy), 0);
        checkEq("reset srcSel", int'(srcSel), 2);
        checkEq("reset rdBank", int'(rdBank), 0);
        checkEq("reset row/col", int'({row, col}), 0);
        checkEq("reset enables", int'({macEn, macClr, stWr, outWr, done, readSel}), 0);
        @(negedge iClk);
        rst = 1'b0; dRst = 1'b0;

        // Full step with a second start ignored mid-step
        @(negedge iClk);
        macEnCnt = 0; macClrCnt = 0; busyErr = 0;
        pushStep(0, cyc + 371);
        start = 1'b1;
        for (int j = 1; j <= 371; j++) begin
            @(negedge iClk);
            start = (j == 100);
            #1;
            if (!busy) busyErr++;
        end
        checkEq("busy through step", busyErr, 0);
        waitDone(20);
        repeat (5) @(negedge iClk);
        checkEq("macEn count", macEnCnt, 352);
        checkEq("macClr count", macClrCnt, 18);
        checkEq("stateWr remaining", wbQ.size(), 0);
        checkEq("outWr remaining", outQ.size(), 0);
        checkEq("bank after step", int'(rdBank), 1);

        // Asynchronous reset mid-operation
        monEn = 1'b0;
        @(negedge iClk); start = 1'b1;
        @(negedge iClk); start = 1'b0;
        repeat (40) @(negedge iClk);
        #2 rst = 1'b1;
        #1;
        checkEq("midrst busy", int'(busy), 0);
        checkEq("midrst rdBank", int'(rdBank), 0);
        checkEq("midrst srcSel", int'(srcSel), 2);
        checkEq("midrst enables", int'({macEn, macClr, stWr, outWr, done}), 0);
        @(negedge iClk); rst = 1'b0;
        repeat (3) @(negedge iClk);
        checkEq("idle after reset", int'(busy), 0);
        monEn = 1'b1;

        // Hold for 5 cycles at RES_REC row 3 col 7
        @(negedge iClk);
        macEnCnt = 0; macClrCnt = 0;
        pushStep(0, cyc + 376);
        start = 1'b1;
        @(negedge iClk); start = 1'b0;
        n = 0;
        while (!(srcSel == 2'd1 && readSel == 1'b0 && row == 8'd3 && col == 8'd7) && n < 2000) begin
            @(negedge iClk);
            n++;
        end
        checkEq("hold point reached", int'(n < 2000), 1);
        hold = 1'b1; holdActive = 1'b1;
        repeat (5) @(negedge iClk);
        hold = 1'b0; holdActive = 1'b0;
        waitDone(600);
        repeat (2) @(negedge iClk);
        checkEq("hold macEn count", macEnCnt, 352);
        checkEq("hold macClr count", macClrCnt, 18);
        checkEq("bank after hold step", int'(rdBank), 1);

        // Back-to-back timesteps with start held high
        @(negedge iClk);
        pushStep(1, cyc + 371);
        pushStep(0, cyc + 371 + 372);
        start = 1'b1;
        repeat (400) @(negedge iClk);
        start = 1'b0;
        waitDone(500);
        repeat (3) @(negedge iClk);
        checkEq("b2b queues drained", wbQ.size() + outQ.size(), 0);
        checkEq("bank after two steps", int'(rdBank), 1);

        // Degenerate single neuron/input/output instance
        @(negedge iClk); dStart = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge iClk);
            dStart = 1'b0;
            #1;
            checkEq($sformatf("deg cycle %0d", j),
                    int'({dBusy, dDone, dMacEn, dMacClr, dStWr, dOutWr, dReadSel, dSrcSel}),
                    int'(degExp[j]));
        end
        checkEq("deg bank toggled", int'(dRdBank), 1);

        dDoneCnt = 0;
        @(negedge iClk); dStart = 1'b1;
        @(negedge iClk); dStart = 1'b0;
        repeat (2) @(negedge iClk);
        #2 dRst = 1'b1;
        #1;
        checkEq("deg reset busy", int'(dBusy), 0);
        checkEq("deg reset bank", int'(dRdBank), 0);
        @(negedge iClk); dRst = 1'b0;
        repeat (10) @(negedge iClk);
        checkEq("deg no done after reset", dDoneCnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/esn_step_sequencer.md
Name: esn_step_sequencer

Overview:
Sequences one Echo State Network timestep over a single shared MAC datapath.
- Reservoir phase: for each neuron, accumulates input weights, then recurrent weights, then writes the clipped state.
- Readout phase: for each output, accumulates over the new reservoir state and writes the result.
- Sits between the top-level handler and the weight/state memories. Reservoir state is double-buffered: reads come from one bank, writes go to the other, and the banks swap at the end of each timestep.

Parameters:
N_NEUR, 16, reservoir neuron count (>=1)
N_IN, 4, input vector length (>=1)
N_OUT, 2, readout output count (>=1)
IW, 8, index width; must satisfy 2**IW >= max(N_NEUR, N_IN, N_OUT)

Ports:
iClk  in  1  clock, rising edge
iRst  in  1  asynchronous reset, active-high
iStart  in  1  start one timestep; sampled only in IDLE
iHold  in  1  memory/datapath stall; freezes sequencing
oBusy  out  1  high in every state except IDLE
oDone  out  1  one-cycle pulse in DONE state
oMacEn  out  1  accumulate weight[row][col] * operand this cycle
oMacClr  out  1  clear accumulator before this cycle's product (first column of a row)
oSrcSel  out  2  operand source: 0 input vector, 1 reservoir state, 2 none
oRowIdx  out  IW  neuron index (reservoir) or output index (readout)
oColIdx  out  IW  column index within current operand vector
oRdBank  out  1  reservoir bank read this timestep
oStateWrEn  out  1  write clipped accumulator to state[!oRdBank][oRowIdx]
oOutWrEn  out  1  write accumulator to out[oRowIdx]
oReadSel  out  1  0 reservoir weights, 1 readout weights

Behaviour:
Reset (iRst high, async):
- State IDLE, row/col counters 0, oRdBank 0.
- All outputs 0, except oSrcSel = 2.

State machine: one-hot, registered. All outputs are decoded from registered state and counters; iHold gates enables combinationally.
- IDLE -> RES_IN when iStart = 1. iStart in any other state is ignored.
- RES_IN: oSrcSel 0, oReadSel 0, oMacEn 1; oMacClr 1 when col = 0.
  - col counts 0..N_IN-1.
  - At N_IN-1: col <= 0, go to RES_REC.
- RES_REC: oSrcSel 1 (reads bank oRdBank), oMacEn 1.
  - col counts 0..N_NEUR-1.
  - At N_NEUR-1: col <= 0, go to RES_WB.
- RES_WB: oStateWrEn 1, oSrcSel 2.
  - If row = N_NEUR-1: row <= 0, go to RO_MAC.
  - Else row++, go to RES_IN.
- RO_MAC: oSrcSel 1, reads bank !oRdBank (the freshly written state), oReadSel 1, oMacEn 1; oMacClr 1 when col = 0.
  - col counts 0..N_NEUR-1.
  - At N_NEUR-1: col <= 0, go to RO_WB.
- RO_WB: oOutWrEn 1.
  - If row = N_OUT-1: row <= 0, go to DONE.
  - Else row++, go to RO_MAC.
- DONE: oDone 1; oRdBank toggles; next state IDLE. DONE is unconditional and ignores iHold.

Timing:
- Accumulator is registered: the product issued in cycle t is included in the sum visible in cycle t+1. WB states therefore see the complete sum.
- Latency, iStart edge to oDone cycle (no hold): 1 + N_NEUR*(N_IN+N_NEUR+1) + N_OUT*(N_NEUR+1). Defaults: 1 + 336 + 34 = 371 cycles.

iHold:
- In any state other than IDLE or DONE, iHold = 1 freezes state and counters.
- While frozen, oMacEn, oMacClr, oStateWrEn and oOutWrEn are forced 0. oRowIdx, oColIdx, oSrcSel and oReadSel hold their values.
- Each hold cycle adds exactly one cycle to the latency.

Boundary conditions:
- N_IN = 1 or N_NEUR = 1: the single column is also the terminal column. oMacClr and the transition occur in the same cycle.
- iRst mid-operation: immediate return to IDLE with oRdBank 0; partial writes are abandoned.
- iStart held high continuously: a new timestep begins the cycle after DONE (IDLE lasts one cycle).

Decomposition:
Package esn_ctrl_pkg:
- One-hot state localparams IDLE, RES_IN, RES_REC, RES_WB, RO_MAC, RO_WB, DONE.
- oSrcSel encodings SRC_IN = 0, SRC_STATE = 1, SRC_NONE = 2.

Sub-module idx_counter:
- Parameters IW, LIMIT.
- Inputs: en, clr. Outputs: count, last (count == LIMIT-1).
- Wraps to 0 on en while last.
- Used for the col counter (limit chosen per state) and the row counter; limit is a port input driven per state.

Test Plan:
- Reset: iRst = 1 mid-cycle -> all outputs 0, oSrcSel = 2, oRdBank = 0 immediately (async).
- Full step, defaults, iHold = 0: iStart pulse -> oDone exactly 371 cycles later. Also check:
  - 16 oStateWrEn pulses with oRowIdx 0..15.
  - 2 oOutWrEn pulses with oRowIdx 0..1.
  - 18 oMacClr pulses.
  - oMacEn count = 16*20 + 2*16 = 352.
- Hold: iHold = 1 for 5 cycles starting in RES_REC at row 3, col 7 -> indices frozen at 3/7, no enables during hold, oDone at cycle 376.
- Busy start: second iStart pulse at cycle 100 -> ignored; exactly one oDone; oBusy stays 1 through cycle 371.
- Banks: two back-to-back timesteps -> step 1 oRdBank = 0 with readout reading bank 1; step 2 oRdBank = 1 with readout reading bank 0.
- Degenerate: N_NEUR = 1, N_IN = 1, N_OUT = 1 -> latency 1 + 3 + 2 = 6; oMacClr coincides with last column; reset asserted at cycle 3 -> IDLE, no oDone.
